// File: rtl/axi_mem_responder.sv
// Single-beat AXI slave backed by a word-organised register memory.
// Optional read wait states: define UAP_MEM_WAIT_EN to enable READ_WAIT.
module axi_mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          READ_WAIT = 2
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [32:0] SPAN   = 33'(DEPTH) << 2;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [1:0]  DECERR = 2'b11;

`ifdef UAP_MEM_WAIT_EN
  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_RESP, WR_DATA, WR_RESP
  } state_t;
  localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT - 1);
  logic [3:0] r_cnt;
`else
  typedef enum logic [2:0] {
    IDLE, RD_RESP, WR_DATA, WR_RESP
  } state_t;
`endif

  state_t        r_state;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_widx;
  logic [1:0]    r_bresp;
  logic [1:0]    r_rresp;
  logic [31:0]   r_rdata;

  // 33-bit offsets: a borrow lands above SPAN, so below-base is out of range
  logic [32:0]   w_aw_off;
  logic [32:0]   w_ar_off;
  logic [AW-1:0] w_aw_idx;
  logic [AW-1:0] w_ar_idx;
  logic [1:0]    w_aw_resp;
  logic [1:0]    w_ar_resp;
  logic          w_wr_en;
  logic          w_unused;

  function automatic logic [1:0] f_resp(
    input logic [32:0] off,
    input logic [1:0]  lo,
    input logic [2:0]  sz
  );
    logic [1:0] r;
    r = OKAY;
    if (off >= SPAN)
      r = DECERR;
    else if (sz > 3'd2 ||
             (sz == 3'd1 && lo[0]) ||
             (sz == 3'd2 && lo != 2'b00))
      r = SLVERR;
    return r;
  endfunction

  assign w_aw_off  = {1'b0, s_axi_awaddr} - {1'b0, BASE_ADDR};
  assign w_ar_off  = {1'b0, s_axi_araddr} - {1'b0, BASE_ADDR};
  assign w_aw_idx  = w_aw_off[AW+1:2];
  assign w_ar_idx  = w_ar_off[AW+1:2];
  assign w_aw_resp = f_resp(w_aw_off, s_axi_awaddr[1:0], s_axi_awsize);
  assign w_ar_resp = f_resp(w_ar_off, s_axi_araddr[1:0], s_axi_arsize);

  assign s_axi_awready = aresetn && r_state == IDLE;
  assign s_axi_arready = aresetn && r_state == IDLE && !s_axi_awvalid;
  assign s_axi_wready  = aresetn && r_state == WR_DATA;
  assign s_axi_bvalid  = aresetn && r_state == WR_RESP;
  assign s_axi_rvalid  = aresetn && r_state == RD_RESP;
  assign s_axi_rlast   = s_axi_rvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;

  assign w_wr_en = aresetn && r_state == WR_DATA &&
                   s_axi_wvalid && r_bresp == OKAY;
  assign w_unused = &{1'b0, s_axi_wlast, READ_WAIT != 0};

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b])
          r_mem[r_widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_widx  <= '0;
      r_bresp <= OKAY;
      r_rresp <= OKAY;
      r_rdata <= '0;
`ifdef UAP_MEM_WAIT_EN
      r_cnt   <= '0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (s_axi_awvalid) begin
            r_state <= WR_DATA;
            r_widx  <= w_aw_idx;
            r_bresp <= w_aw_resp;
          end else if (s_axi_arvalid) begin
            r_rresp <= w_ar_resp;
            r_rdata <= (w_ar_resp == OKAY) ?
                       r_mem[w_ar_idx] : '0;
`ifdef UAP_MEM_WAIT_EN
            if (READ_WAIT > 0) begin
              r_state <= RD_WAIT;
              r_cnt   <= WAIT_INIT;
            end else begin
              r_state <= RD_RESP;
            end
`else
            r_state <= RD_RESP;
`endif
          end
        end
`ifdef UAP_MEM_WAIT_EN
        RD_WAIT: begin
          if (r_cnt == 4'd0)
            r_state <= RD_RESP;
          else
            r_cnt <= r_cnt - 4'd1;
        end
`endif
        RD_RESP: if (s_axi_rready) r_state <= IDLE;
        WR_DATA: if (s_axi_wvalid) r_state <= WR_RESP;
        WR_RESP: if (s_axi_bready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder: vector table,
// hand-written corner sequences and randomized traffic vs a model.
module tb_axi_mem_responder;

  localparam logic [31:0] B     = 32'h0000_1000;
  localparam int          DEPTH = 64;
  localparam int          RW    = 3;
`ifdef UAP_MEM_WAIT_EN
  localparam int LAT = 1 + RW;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        aresetn;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, awvalid, awready;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, rlast, rvalid, rready;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [DEPTH];

  axi_mem_responder #(
    .BASE_ADDR(B), .DEPTH(DEPTH), .READ_WAIT(RW)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .s_axi_araddr(araddr), .s_axi_arsize(arsize),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_awaddr(awaddr), .s_axi_awsize(awsize),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid),
    .s_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Expected response from the address-map and alignment rules.
  function automatic logic [1:0] m_resp(input logic [31:0] a,
                                        input logic [2:0] sz);
    longint ua, hi;
    ua = longint'(a);
    hi = longint'(B) + 4 * DEPTH;
    if (ua < longint'(B) || ua >= hi) return 2'b11;
    if (sz > 3'd2) return 2'b10;
    if ((ua % (longint'(1) << sz)) != 0) return 2'b10;
    return 2'b00;
  endfunction

  // Called at posedge+1; returns at posedge+1.
  task automatic do_write(input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] d, input logic [3:0] st,
                          input logic [1:0] er, input int hold);
    int n;
    awaddr = a; awsize = sz; awvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 50) begin
      @(posedge clk); #2; n++;
    end
    chk("aw_wait", n < 50, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("wready", wready, 1);
    wdata = d; wstrb = st; wlast = 1'b1; wvalid = 1'b1;
    #1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, er);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", {bvalid, bresp}, {1'b1, er});
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("bvalid_drop", bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] sz,
                         input logic [1:0] er, input logic [31:0] ed,
                         input int hold);
    int n;
    araddr = a; arsize = sz; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 50) begin
      @(posedge clk); #2; n++;
    end
    chk("ar_wait", n < 50, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 1;
    while (!rvalid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("r_latency", n, LAT);
    chk("rresp", rresp, er);
    chk("rdata", rdata, ed);
    chk("rlast", rlast, 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("rvalid_hold", rvalid, 1);
      chk("rdata_hold", rdata, ed);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk("rvalid_drop", rvalid, 0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [31:0] a, d, v;
    logic [2:0]  sz;
    logic [3:0]  st;
    logic [1:0]  er;
    int          idx, sel;

    tbl[0]  = '{1'b1, B + 32'h08,  3'd2, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    tbl[1]  = '{1'b0, B + 32'h08,  3'd2, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, B + 32'h0C,  3'd2, 32'h11223344, 4'hF, 2'b00, 32'h0};
    tbl[3]  = '{1'b1, B + 32'h0C,  3'd0, 32'h000000AA, 4'h1, 2'b00, 32'h0};
    tbl[4]  = '{1'b0, B + 32'h0C,  3'd2, 32'h0, 4'h0, 2'b00, 32'h112233AA};
    tbl[5]  = '{1'b0, B + 32'h100, 3'd2, 32'h0, 4'h0, 2'b11, 32'h0};
    tbl[6]  = '{1'b1, B,           3'd2, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
    tbl[7]  = '{1'b1, B + 32'h02,  3'd2, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
    tbl[8]  = '{1'b0, B,           3'd2, 32'h0, 4'h0, 2'b00, 32'hCAFEF00D};
    tbl[9]  = '{1'b0, B - 32'h04,  3'd2, 32'h0, 4'h0, 2'b11, 32'h0};
    tbl[10] = '{1'b0, B + 32'h01,  3'd1, 32'h0, 4'h0, 2'b10, 32'h0};
    tbl[11] = '{1'b0, B + 32'h08,  3'd3, 32'h0, 4'h0, 2'b10, 32'h0};
    tbl[12] = '{1'b1, B + 32'hFC,  3'd2, 32'h5A5AA5A5, 4'hF, 2'b00, 32'h0};
    tbl[13] = '{1'b0, B + 32'hFC,  3'd2, 32'h0, 4'h0, 2'b00, 32'h5A5AA5A5};
    tbl[14] = '{1'b1, B + 32'h101, 3'd3, 32'h12345678, 4'hF, 2'b11, 32'h0};
    tbl[15] = '{1'b0, B + 32'h0E,  3'd1, 32'h0, 4'h0, 2'b00, 32'h112233AA};
    tbl[16] = '{1'b1, B + 32'h09,  3'd0, 32'h00007700, 4'h2, 2'b00, 32'h0};
    tbl[17] = '{1'b0, B + 32'h08,  3'd2, 32'h0, 4'h0, 2'b00, 32'hDEAD77EF};

    aresetn = 1'b0;
    araddr = '0; arsize = '0; arvalid = 1'b0;
    awaddr = '0; awsize = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; rready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {awready, arready, wready}, 0);
    chk("rst_valid", {bvalid, rvalid, rlast}, 0);
    chk("rst_resp", {bresp, rresp}, 0);
    chk("rst_rdata", rdata, 0);
    aresetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_awready", awready, 1);
    chk("post_rst_arready", arready, 1);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].wr)
        do_write(tbl[i].addr, tbl[i].size, tbl[i].data,
                 tbl[i].strb, tbl[i].resp, i % 4);
      else
        do_read(tbl[i].addr, tbl[i].size, tbl[i].resp,
                tbl[i].rd, i % 4);
    end

    // AW and AR together: write wins, read sees the new data
    awaddr = B + 32'h20; awsize = 3'd2; awvalid = 1'b1;
    araddr = B + 32'h20; arsize = 3'd2; arvalid = 1'b1;
    #1;
    chk("both_awready", awready, 1);
    chk("both_arready", arready, 0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("both_wd_arready", arready, 0);
    chk("both_wready", wready, 1);
    wdata = 32'hA5C3_0F1E; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    chk("both_bvalid", bvalid, 1);
    chk("both_wr_arready", arready, 0);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk("both_idle_arready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    idx = 1;
    while (!rvalid && idx < 50) begin
      @(posedge clk); #1; idx++;
    end
    chk("both_lat", idx, LAT);
    chk("both_rdata", rdata, 32'hA5C3_0F1E);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;

    do_read(B + 32'h20, 3'd2, 2'b00, 32'hA5C3_0F1E, 10);

    // reset while in WR_DATA drops the write
    do_write(B + 32'h10, 3'd2, 32'h600D_F00D, 4'hF, 2'b00, 0);
    awaddr = B + 32'h10; awsize = 3'd2; awvalid = 1'b1;
    #1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("rw_wready", wready, 1);
    wdata = 32'hBAD0_BAD0; wstrb = 4'hF; wvalid = 1'b1;
    aresetn = 1'b0;
    #1;
    chk("rw_rst_wready", wready, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rw_bvalid", bvalid, 0);
    end
    wvalid = 1'b0;
    aresetn = 1'b1;
    @(posedge clk); #1;
    chk("rw_awready", awready, 1);
    chk("rw_bvalid_after", bvalid, 0);
    do_read(B + 32'h10, 3'd2, 2'b00, 32'h600D_F00D, 0);

    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      mdl[i] = d;
      do_write(B + 32'(4 * i), 3'd2, d, 4'hF, 2'b00, 0);
    end

    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)
        a = B + 32'($urandom_range(0, 4 * DEPTH - 1));
      else if (sel == 7)
        a = B + 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
      else if (sel == 8)
        a = B - 32'($urandom_range(1, 8));
      else
        a = $urandom;
      if (sel < 5) a[1:0] = 2'b00;
      sz = ($urandom_range(0, 2) == 0) ?
           3'($urandom_range(0, 3)) : 3'd2;
      er = m_resp(a, sz);
      idx = int'((a - B) >> 2);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        st = 4'($urandom);
        do_write(a, sz, d, st, er, $urandom_range(0, 3));
        if (er == 2'b00) begin
          v = mdl[idx];
          for (int b = 0; b < 4; b++)
            if (st[b]) v[8*b +: 8] = d[8*b +: 8];
          mdl[idx] = v;
        end
      end else begin
        v = (er == 2'b00) ? mdl[idx] : 32'h0;
        do_read(a, sz, er, v, $urandom_range(0, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
